// File: rtl/div_seq.sv
// div_seq: multi-cycle signed restoring divider, one quotient bit per clock
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   ctrl_DIV  start pulse; operands sampled on the edge where it is high
//   dividend  signed dividend
//   divisor   signed divisor
//   quotient  signed quotient (truncated toward zero), registered
//   remainder signed remainder (sign of dividend), registered
//   rdy       one-cycle result-valid pulse
//   exception divide-by-zero / overflow flag, held until the next start
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             rdy,
  output logic             exception
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d, sh, t;
  logic [WIDTH-1:0] qr_q, qr_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d, a_dd, a_dv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, rdy_q, rdy_d, exc_q, exc_d, ovf;
  assign a_dd = dividend[WIDTH-1] ? -dividend : dividend;
  assign a_dv = divisor[WIDTH-1] ? -divisor : divisor;
  assign ovf  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign sh   = {r_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign t    = sh - {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    qr_d    = qr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    rdy_d   = rdy_q;
    exc_d   = exc_q;
    if (ctrl_DIV) begin
      r_d     = '0;
      qr_d    = a_dd;
      dvs_d   = a_dv;
      cnt_d   = '0;
      sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sr_d    = dividend[WIDTH-1];
      dz_d    = divisor == '0;
      rdy_d   = 1'b0;
      exc_d   = 1'b0;
      state_d = (divisor == '0 || ovf) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          // borrow out of the trial subtraction means the divisor did not fit
          r_d     = t[WIDTH] ? sh : t;
          qr_d    = {qr_q[WIDTH-2:0], ~t[WIDTH]};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : RUN;
        end
        FIX: begin
          quo_d   = sq_q ? -qr_q : qr_q;
          rem_d   = sr_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
          exc_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          // rdy low on entry marks a special case arriving straight from start
          if (rdy_q) begin
            rdy_d   = 1'b0;
            state_d = IDLE;
          end else begin
            quo_d = dz_q ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            rem_d = '0;
            exc_d = 1'b1;
            rdy_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      qr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      qr_q    <= qr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      rdy_q   <= rdy_d;
      exc_q   <= exc_d;
    end
  end
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign rdy       = rdy_q;
  assign exception = exc_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and swept checks of the sequential signed divider
module tb_div_seq;
  logic        clk = 0, reset_n = 0, ctrl_DIV = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic [31:0] quotient, remainder;
  logic        rdy, exception;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_DIV(ctrl_DIV), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .rdy(rdy), .exception(exception)
  );
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    ctrl_DIV = 1;
    @(negedge clk);
    ctrl_DIV = 0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee, input int el);
    logic [31:0] pq, pr;
    int lat;
    bit held;
    pq = quotient;
    pr = remainder;
    lat = 0;
    held = 1;
    start(a, b);
    n_chk++;
    if (rdy !== 1'b0 || exception !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_clear: rdy=%b exc=%b, required 0 0", nm, rdy, exception);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
      if (quotient !== pq || remainder !== pr) held = 0;
    end
    n_chk++;
    if (lat !== el) begin n_fail++; $display("FAIL %s latency: got %0d, required %0d", nm, lat, el); end
    n_chk++;
    if (!held) begin n_fail++; $display("FAIL %s hold_while_busy: outputs changed before rdy", nm); end
    n_chk++;
    if (quotient !== eq) begin n_fail++; $display("FAIL %s quotient: got %h, required %h", nm, quotient, eq); end
    n_chk++;
    if (remainder !== er) begin n_fail++; $display("FAIL %s remainder: got %h, required %h", nm, remainder, er); end
    n_chk++;
    if (exception !== ee) begin n_fail++; $display("FAIL %s exception: got %b, required %b", nm, exception, ee); end
    @(negedge clk);
    n_chk++;
    if (rdy !== 1'b0 || quotient !== eq || remainder !== er || exception !== ee) begin
      n_fail++;
      $display("FAIL %s after_pulse: rdy=%b q=%h r=%h exc=%b, required 0 %h %h %b", nm, rdy, quotient, remainder, exception, eq, er, ee);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++;
    if (quotient !== 0 || remainder !== 0 || rdy !== 0 || exception !== 0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h r=%h rdy=%b exc=%b, required all 0", quotient, remainder, rdy, exception);
    end
    reset_n = 1;
  endtask
  task automatic test_basic;
    run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
    run_div("-7/2", -32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 33);
    run_div("7/-2", 32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, 33);
    run_div("-7/-2", -32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, 33);
    run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
  endtask
  task automatic test_special;
    run_div("5/0", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1);
    run_div("clear_exc", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
  endtask
  task automatic test_extremes;
    run_div("max/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 33);
    run_div("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 33);
    run_div("100/200", 32'd100, 32'd200, 32'd0, 32'd100, 1'b0, 33);
    run_div("min/min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 33);
    run_div("max/min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 33);
  endtask
  task automatic test_sweep;
    for (int i = 0; i < 1000; i++) begin
      int signed a, b, qe, re;
      a = $urandom;
      b = (i % 2 == 0) ? int'($urandom) : int'($urandom_range(1, 1000));
      if (i % 4 == 1) b = -b;
      if (i % 8 == 3) a = int'($urandom_range(0, 5000)) - 2500;
      if (b == 0) b = 1;
      if (a == 32'sh8000_0000 && b == -1) b = 3;
      qe = a / b;
      re = a % b;
      run_div("sweep", a, b, qe, re, 1'b0, 33);
    end
  endtask
  task automatic test_restart;
    int lat;
    bit early;
    lat = 0;
    early = 0;
    start(32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) early = 1;
    end
    start(32'd50, 32'd6);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_chk++;
    if (early || lat !== 33) begin n_fail++; $display("FAIL restart_latency: early=%b lat=%0d, required 0 33", early, lat); end
    n_chk++;
    if (quotient !== 32'd8 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL restart_result: q=%h r=%h, required 8 2", quotient, remainder);
    end
    @(negedge clk);
    n_chk++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL restart_pulse_width: rdy=%b, required 0", rdy); end
  endtask
  task automatic test_reset_abort;
    bit seen;
    seen = 0;
    start(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #2 reset_n = 0;
    #1;
    n_chk++;
    if (quotient !== 0 || remainder !== 0 || rdy !== 0 || exception !== 0) begin
      n_fail++;
      $display("FAIL async_reset: q=%h r=%h rdy=%b exc=%b, required all 0", quotient, remainder, rdy, exception);
    end
    @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL abort_no_rdy: rdy seen after reset, required none"); end
    run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_special();
    test_extremes();
    test_restart();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
